// File: rtl/pixel_packetizer.sv
// Pixel packetizer: accepts raster-order pixels and emits them as sop/eop-framed
// packets through a small registered output FIFO. Scan-order violations close the packet.
module pixel_packetizer #(
  parameter int DATA_WIDTH    = 32,
  parameter int RBG_SIZE      = 24,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_y,
  input  logic [RBG_SIZE-1:0]   in_colour,
  output logic [RBG_SIZE-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  frame_err,
  output logic [15:0]           frame_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = RBG_SIZE + 2;
  localparam logic [DATA_WIDTH-1:0] LastX = DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] TopY  = DATA_WIDTH'(SCREEN_HEIGHT - 1);

  typedef enum logic {SYNC, STREAM} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] expX_q, expX_d;
  logic [DATA_WIDTH-1:0] expY_q, expY_d;
  logic [15:0]           frameCount_q, frameCount_d;
  logic                  frameErr_q, frameErr_d;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wrPtr_q, rdPtr_q;
  logic [AW:0]           count_q;
  logic [EW-1:0]         head;

  logic full, empty, accept, push, pop, pushSop, pushEop;
  logic isStart, isExpected, expIsEnd;

  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = reset && !full;
  assign out_valid = reset && !empty;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Entry layout is {sop, eop, colour}; outputs are forced low whenever nothing is valid
  assign head        = mem_q[rdPtr_q];
  assign out_data    = out_valid ? head[RBG_SIZE-1:0] : '0;
  assign out_sop     = out_valid && head[EW-1];
  assign out_eop     = out_valid && head[EW-2];
  assign frame_err   = reset && frameErr_q;
  assign frame_count = reset ? frameCount_q : 16'd0;

  assign isStart    = (in_x == '0) && (in_y == TopY);
  assign isExpected = (in_x == expX_q) && (in_y == expY_q);
  assign expIsEnd   = (expX_q == LastX) && (expY_q == '0);

  always_comb begin
    state_d      = state_q;
    expX_d       = expX_q;
    expY_d       = expY_q;
    frameCount_d = frameCount_q;
    frameErr_d   = 1'b0;
    push         = 1'b0;
    pushSop      = 1'b0;
    pushEop      = 1'b0;
    if (accept) begin
      case (state_q)
        SYNC: begin
          if (isStart) begin
            push    = 1'b1;
            pushSop = 1'b1;
            // A 1x1 screen makes the start pixel also the end pixel
            if ((LastX == '0) && (TopY == '0)) begin
              pushEop      = 1'b1;
              frameCount_d = frameCount_q + 16'd1;
            end else begin
              state_d = STREAM;
              if (LastX == '0) begin
                expX_d = '0;
                expY_d = TopY - DATA_WIDTH'(1);
              end else begin
                expX_d = DATA_WIDTH'(1);
                expY_d = TopY;
              end
            end
          end
        end
        STREAM: begin
          push = 1'b1;
          if (isExpected) begin
            if (expIsEnd) begin
              pushEop      = 1'b1;
              frameCount_d = frameCount_q + 16'd1;
              state_d      = SYNC;
              expX_d       = '0;
              expY_d       = TopY;
            end else if (expX_q == LastX) begin
              expX_d = '0;
              expY_d = expY_q - DATA_WIDTH'(1);
            end else begin
              expX_d = expX_q + DATA_WIDTH'(1);
            end
          end else begin
            pushEop    = 1'b1;
            frameErr_d = 1'b1;
            state_d    = SYNC;
            expX_d     = '0;
            expY_d     = TopY;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= SYNC;
      expX_q       <= '0;
      expY_q       <= TopY;
      frameCount_q <= '0;
      frameErr_q   <= 1'b0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      expX_q       <= expX_d;
      expY_q       <= expY_d;
      frameCount_q <= frameCount_d;
      frameErr_q   <= frameErr_d;
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset: the empty pointers hide stale entries
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {pushSop, pushEop, in_colour};
  end

endmodule

// File: doc/pixel_packetizer.md
PIXEL_PACKETIZER -- requirements
Module: pixel_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the coordinate inputs.
REQ-002 SHALL have parameter RBG_SIZE, default 24: width of the colour field.
REQ-003 SHALL have parameter SCREEN_WIDTH, default 640: number of pixels per line.
REQ-004 SHALL have parameter SCREEN_HEIGHT, default 480: number of lines per frame.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: number of output buffer entries, a power of 2 and at least 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-008 SHALL have port in_valid, input, 1 bit: the pixel producer presents a pixel.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept a pixel this cycle.
REQ-010 SHALL have port in_x, input, DATA_WIDTH bits: pixel column.
REQ-011 SHALL have port in_y, input, DATA_WIDTH bits: pixel row.
REQ-012 SHALL have port in_colour, input, RBG_SIZE bits: pixel colour.
REQ-013 SHALL have port out_data, output, RBG_SIZE bits: colour at the head of the FIFO.
REQ-014 SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-015 SHALL have port out_ready, input, 1 bit: the downstream sink accepts the head.
REQ-016 SHALL have port out_sop, output, 1 bit: the head is the first pixel of a packet.
REQ-017 SHALL have port out_eop, output, 1 bit: the head is the last pixel of a packet.
REQ-018 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a scan-order violation.
REQ-019 SHALL have port frame_count, output, 16 bits: number of complete frames packetized.

Function
REQ-020 A pixel SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
- in_ready = !fifo_full.
- No push while full, even if a pop occurs in the same cycle.
REQ-021 The pixel scan order SHALL be as follows.
- x counts 0..SCREEN_WIDTH-1 within a line.
- y counts down from SCREEN_HEIGHT-1 to 0 by line.
- The start pixel is (0, SCREEN_HEIGHT-1); the end pixel is (SCREEN_WIDTH-1, 0).
REQ-022 The block SHALL use an FSM with two states, SYNC and STREAM.
REQ-023 In SYNC:
- An accepted pixel at the start coordinates is pushed with sop=1.
- The expected position is set to (1, SCREEN_HEIGHT-1) and the FSM goes to STREAM.
- Any other accepted pixel is discarded silently, with no frame_err.
REQ-024 In STREAM, an accepted pixel equal to the expected position SHALL be pushed with sop=0.
- The expected x increments.
- At x=SCREEN_WIDTH-1 the expected x wraps to 0 and the expected y decrements.
REQ-025 In STREAM, an accepted end pixel SHALL be pushed with eop=1.
- frame_count increments in the same cycle, wrapping from 0xFFFF to 0.
- The FSM returns to SYNC.
REQ-026 In STREAM, an accepted pixel that differs from the expected position SHALL:
- be pushed with eop=1, closing the packet;
- pulse frame_err high for exactly one cycle;
- leave frame_count unchanged;
- return the FSM to SYNC.
REQ-027 SHALL use a mismatch pixel equal to the start coordinates only to close the old packet; it does not open a new one.
REQ-028 SHALL give an accepted pixel a latency of 1 cycle to the output.
- An accepted pixel in cycle N is visible on out_* in cycle N+1 if the FIFO was empty.
- FIFO entries are registered.
REQ-029 SHALL set out_valid = !fifo_empty.
- The head pops when out_valid=1 and out_ready=1.
- out_data, out_sop and out_eop hold stable while out_valid=1 and out_ready=0.
REQ-030 SHALL allow push and pop in the same cycle when the FIFO is not full; occupancy is then unchanged.
REQ-031 Coordinate comparison SHALL use the full DATA_WIDTH.
- Out-of-range values, such as x >= SCREEN_WIDTH, are mismatches in STREAM.
- Out-of-range values are discards in SYNC.
REQ-032 SHALL allow for a frame of a single pixel: when SCREEN_WIDTH=SCREEN_HEIGHT=1, the start pixel is pushed with sop=1 and eop=1, frame_count increments, and the FSM stays in SYNC.

Reset
REQ-033 While reset=0, the following outputs SHALL be 0: in_ready, out_valid, out_sop, out_eop, out_data, frame_err, frame_count.
REQ-034 While reset=0:
- The FIFO is emptied.
- The FSM goes to SYNC.
- The expected position is set to (0, SCREEN_HEIGHT-1).
- Inputs are ignored.
REQ-035 SHALL raise in_ready in the first cycle after reset returns to 1.
REQ-036 Reset mid-frame SHALL drop the partial packet without emitting eop or frame_err.

Verification
(Use SCREEN_WIDTH=4, SCREEN_HEIGHT=3, FIFO_DEPTH=4.)
REQ-037 Full frame, out_ready=1: drive 12 pixels in order → 12 outputs; sop only on (0,2), eop only on (3,0); frame_count=1; frame_err never asserted.
REQ-038 Backpressure: out_ready=0 while 5 pixels are offered → 4 accepted, in_ready=0 after the 4th; raise out_ready → order and colours preserved, with no loss or duplication.
REQ-039 Order violation: send (0,2), (1,2), (3,2) → third pixel output with eop=1; frame_err high for 1 cycle; frame_count unchanged; next (1,2) is discarded.
REQ-040 Sync: send (2,1), (3,1), then a full frame → first two discarded, no frame_err; frame packetized normally; frame_count=1.
REQ-041 Reset: assert reset=0 after 6 pixels of a frame → out_valid=0 and frame_count=0; after release, a new full frame yields sop..eop with frame_count=1.
REQ-042 Wrap: preload frame_count=0xFFFF via 65535 frames, or force it in simulation; complete one more frame → frame_count=0.
